// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-lite to N-slave APB bridge.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } bridge_state_e;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/apb_bridge_dec.sv
// Slave decoder: address-to-index extraction plus one-hot select and return-path mux.
// Purely combinational, no latency; no backpressure of its own.
module apb_bridge_dec
  import apb_bridge_pkg::*;
#(
  parameter int NUM_SLV       = 8,
  parameter int ADDR_W        = 40,
  parameter int DATA_W        = 32,
  parameter int SLV_SIZE_LOG2 = 12,
  parameter int IDX_W         = 3
) (
  input  logic [ADDR_W-1:0]         haddr,
  input  logic [IDX_W-1:0]          sel_idx,
  output logic [IDX_W-1:0]          req_idx,
  output logic                      req_vld,
  output logic [NUM_SLV-1:0]        sel_onehot,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  output logic [DATA_W-1:0]         prdata_sel,
  output logic                      pready_sel,
  output logic                      pslverr_sel
);

  logic unused_haddr;

  assign unused_haddr = ^haddr;
  assign req_idx      = haddr[SLV_SIZE_LOG2 +: IDX_W];
  assign req_vld      = int'(req_idx) < NUM_SLV;

  // An out-of-range sel_idx yields no select bit and an all-zero return path.
  always_comb begin
    sel_onehot  = '0;
    prdata_sel  = '0;
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_onehot[i] = 1'b1;
        prdata_sel    = prdata[i*DATA_W +: DATA_W];
        pready_sel    = pready[i];
        pslverr_sel   = pslverr[i];
      end
    end
  end

endmodule

// File: rtl/apb_bridge_nslv.sv
// AHB-lite to APB bridge fanning out to NUM_SLV slaves; min 2-cycle data phase (SETUP+ACCESS).
// PREADY low stretches ACCESS (hready held low); PSLVERR, decode miss and timeout give 2-cycle ERROR.
module apb_bridge_nslv
  import apb_bridge_pkg::*;
#(
  parameter int NUM_SLV       = 8,
  parameter int ADDR_W        = 40,
  parameter int DATA_W        = 32,
  parameter int SLV_SIZE_LOG2 = 12,
  parameter int TIMEOUT_CYC   = 256
) (
  input  logic                      hclk,
  input  logic                      hrst,
  input  logic                      harb_apb_hsel,
  input  logic [1:0]                harb_xx_htrans,
  input  logic                      harb_xx_hready_in,
  input  logic [ADDR_W-1:0]         harb_xx_haddr,
  input  logic                      harb_xx_hwrite,
  input  logic [DATA_W-1:0]         harb_xx_hwdata,
  output logic [DATA_W-1:0]         apb_harb_hrdata,
  output logic                      apb_harb_hready,
  output logic [1:0]                apb_harb_hresp,
  output logic [ADDR_W-1:0]         apb_xx_paddr,
  output logic                      apb_xx_pwrite,
  output logic [DATA_W-1:0]         apb_xx_pwdata,
  output logic                      apb_xx_penable,
  output logic [NUM_SLV-1:0]        psel,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  output logic                      bridge_err_int
);

  localparam int          IDX_W    = (NUM_SLV > 1) ? clog2(NUM_SLV) : 1;
  localparam int          CNT_W    = (clog2(TIMEOUT_CYC + 1) > 0) ? clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit          TO_EN    = (TIMEOUT_CYC != 0);
  localparam int unsigned TO_LAST  = TO_EN ? TIMEOUT_CYC - 1 : 0;

  bridge_state_e     state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [IDX_W-1:0]   req_idx;
  logic               req_vld;
  logic [NUM_SLV-1:0] sel_onehot;
  logic [DATA_W-1:0]  prdata_sel;
  logic               pready_sel;
  logic               pslverr_sel;
  logic               psel_act;
  logic               req;

  apb_bridge_dec #(
    .NUM_SLV       (NUM_SLV),
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .SLV_SIZE_LOG2 (SLV_SIZE_LOG2),
    .IDX_W         (IDX_W)
  ) u_dec (
    .haddr       (harb_xx_haddr),
    .sel_idx     (idx_q),
    .req_idx     (req_idx),
    .req_vld     (req_vld),
    .sel_onehot  (sel_onehot),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .prdata_sel  (prdata_sel),
    .pready_sel  (pready_sel),
    .pslverr_sel (pslverr_sel)
  );

  assign req = harb_apb_hsel & harb_xx_hready_in & ((harb_xx_htrans & HTRANS_NONSEQ) != 2'b00);

  always_comb begin
    state_d         = state_q;
    paddr_d         = paddr_q;
    pwrite_d        = pwrite_q;
    pwdata_d        = pwdata_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    psel_act        = 1'b0;
    apb_xx_penable  = 1'b0;
    apb_xx_pwdata   = pwdata_q;
    apb_harb_hready = 1'b1;
    apb_harb_hresp  = HRESP_OKAY;
    apb_harb_hrdata = '0;
    bridge_err_int  = 1'b0;

    case (state_q)
      ST_SETUP: begin
        psel_act        = 1'b1;
        apb_harb_hready = 1'b0;
        apb_xx_pwdata   = harb_xx_hwdata;
        pwdata_d        = harb_xx_hwdata;
        state_d         = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel_act        = 1'b1;
        apb_xx_penable  = 1'b1;
        apb_harb_hready = 1'b0;
        if (pready_sel) begin
          if (pslverr_sel) begin
            state_d = ST_ERR1;
          end else begin
            apb_harb_hready = 1'b1;
            apb_harb_hrdata = pwrite_q ? '0 : prdata_sel;
            state_d         = ST_IDLE;
          end
        end else if (TO_EN && (cnt_q == CNT_W'(TO_LAST))) begin
          state_d = ST_ERR1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ERR1: begin
        apb_harb_hready = 1'b0;
        apb_harb_hresp  = HRESP_ERROR;
        bridge_err_int  = 1'b1;
        state_d         = ST_ERR2;
      end
      ST_ERR2: begin
        apb_harb_hresp = HRESP_ERROR;
        state_d        = ST_IDLE;
      end
      default: ;
    endcase

    // A new address phase is taken whenever the bus sees hready high, overriding the step above.
    if (req && apb_harb_hready) begin
      paddr_d  = harb_xx_haddr;
      pwrite_d = harb_xx_hwrite;
      idx_d    = req_idx;
      cnt_d    = '0;
      state_d  = req_vld ? ST_SETUP : ST_ERR1;
    end
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign psel          = psel_act ? sel_onehot : '0;
  assign apb_xx_paddr  = paddr_q;
  assign apb_xx_pwrite = pwrite_q;

endmodule

// File: tb/tb_apb_bridge_nslv.sv
// Directed bench for apb_bridge_nslv: main instance with a short timeout, second with timeout off.
module tb_apb_bridge_nslv;

  localparam int NS = 9;
  localparam int AW = 40;
  localparam int DW = 32;

  logic hclk = 1'b0;
  logic hrst, hsel, hsel_nto, hready_in, hwrite;
  logic [1:0]     htrans;
  logic [AW-1:0]  haddr;
  logic [DW-1:0]  hwdata;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0]    pready, pslverr;

  logic [DW-1:0] hrdata, pwdata;
  logic          hready_o, pwrite, penable, err_int;
  logic [1:0]    hresp;
  logic [AW-1:0] paddr;
  logic [NS-1:0] psel;

  logic [8*DW-1:0] prdata_nto;
  logic [7:0]      pready_nto, pslverr_nto, nto_psel;
  logic [DW-1:0]   nto_hrdata, nto_pwdata;
  logic            nto_hready, nto_pwrite, nto_penable, nto_err_int;
  logic [1:0]      nto_hresp;
  logic [AW-1:0]   nto_paddr;

  int n_chk  = 0;
  int n_pass = 0;
  int n_low;
  int n_err;

  always #5 hclk = ~hclk;

  // NUM_SLV=9 gives a 4-bit index field, so window 9 is an unmapped decode.
  apb_bridge_nslv #(.NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW), .SLV_SIZE_LOG2(12), .TIMEOUT_CYC(4)) u_dut (
    .hclk(hclk), .hrst(hrst), .harb_apb_hsel(hsel), .harb_xx_htrans(htrans),
    .harb_xx_hready_in(hready_in), .harb_xx_haddr(haddr), .harb_xx_hwrite(hwrite),
    .harb_xx_hwdata(hwdata), .apb_harb_hrdata(hrdata), .apb_harb_hready(hready_o),
    .apb_harb_hresp(hresp), .apb_xx_paddr(paddr), .apb_xx_pwrite(pwrite),
    .apb_xx_pwdata(pwdata), .apb_xx_penable(penable), .psel(psel), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .bridge_err_int(err_int)
  );

  apb_bridge_nslv #(.NUM_SLV(8), .ADDR_W(AW), .DATA_W(DW), .SLV_SIZE_LOG2(12), .TIMEOUT_CYC(0)) u_dut_nto (
    .hclk(hclk), .hrst(hrst), .harb_apb_hsel(hsel_nto), .harb_xx_htrans(htrans),
    .harb_xx_hready_in(hready_in), .harb_xx_haddr(haddr), .harb_xx_hwrite(hwrite),
    .harb_xx_hwdata(hwdata), .apb_harb_hrdata(nto_hrdata), .apb_harb_hready(nto_hready),
    .apb_harb_hresp(nto_hresp), .apb_xx_paddr(nto_paddr), .apb_xx_pwrite(nto_pwrite),
    .apb_xx_pwdata(nto_pwdata), .apb_xx_penable(nto_penable), .psel(nto_psel),
    .prdata(prdata_nto), .pready(pready_nto), .pslverr(pslverr_nto), .bridge_err_int(nto_err_int)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic ahb_req(input logic [AW-1:0] a, input logic w);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = w;
  endtask

  task automatic ahb_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    hrst = 1'b1; hsel = 1'b0; hsel_nto = 1'b0; htrans = 2'b00; hready_in = 1'b1;
    haddr = '0; hwrite = 1'b0; hwdata = '0;
    prdata = '0; pready = '1; pslverr = '0;
    pready_nto = '0; pslverr_nto = '0;
    for (int i = 0; i < 8; i++) prdata_nto[i*DW +: DW] = 32'h7777_0000 + 32'(i);
    repeat (2) @(negedge hclk);
    hrst = 1'b0;
    #1;
    chk("rst_psel", 64'(psel), 0);
    chk("rst_penable", 64'(penable), 0);
    chk("rst_paddr", 64'(paddr), 0);
    chk("rst_pwrite", 64'(pwrite), 0);
    chk("rst_pwdata", 64'(pwdata), 0);
    chk("rst_hready", 64'(hready_o), 1);
    chk("rst_hresp", 64'(hresp), 0);
    chk("rst_hrdata", 64'(hrdata), 0);
    chk("rst_err_int", 64'(err_int), 0);

    // Write slave 2, zero wait states
    ahb_req(40'h2004, 1'b1);
    @(negedge hclk); ahb_idle(); hwdata = 32'hA5A5_0001; #1;
    chk("wr_setup_psel", 64'(psel), 64'h004);
    chk("wr_setup_penable", 64'(penable), 0);
    chk("wr_setup_hready", 64'(hready_o), 0);
    chk("wr_setup_pwdata", 64'(pwdata), 64'hA5A5_0001);
    chk("wr_setup_paddr", 64'(paddr), 64'h2004);
    chk("wr_setup_pwrite", 64'(pwrite), 1);
    @(negedge hclk); hwdata = 32'hDEAD_BEEF; #1;
    chk("wr_acc_psel", 64'(psel), 64'h004);
    chk("wr_acc_penable", 64'(penable), 1);
    chk("wr_acc_pwdata", 64'(pwdata), 64'hA5A5_0001);
    chk("wr_acc_hready", 64'(hready_o), 1);
    chk("wr_acc_hresp", 64'(hresp), 0);
    chk("wr_acc_hrdata", 64'(hrdata), 0);
    @(negedge hclk); #1;
    chk("wr_idle_psel", 64'(psel), 0);
    chk("wr_idle_penable", 64'(penable), 0);

    // BUSY transfer type must not start an APB access
    hsel = 1'b1; htrans = 2'b01; haddr = 40'h2000;
    @(negedge hclk); ahb_idle(); #1;
    chk("busy_psel", 64'(psel), 0);
    chk("busy_hready", 64'(hready_o), 1);

    // Read slave 5 with three PREADY waits
    ahb_req(40'h5008, 1'b0); pready[5] = 1'b0; prdata[5*DW +: DW] = 32'h1234_5678;
    n_low = 0;
    @(negedge hclk); ahb_idle(); #1;
    chk("rd_setup_psel", 64'(psel), 64'h020);
    if (hready_o == 1'b0) n_low++;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk); #1;
      chk("rd_wait_penable", 64'(penable), 1);
      if (hready_o == 1'b0) n_low++;
    end
    @(negedge hclk); pready[5] = 1'b1; #1;
    chk("rd_wait_len", 64'(n_low), 4);
    chk("rd_done_hready", 64'(hready_o), 1);
    chk("rd_done_hrdata", 64'(hrdata), 64'h1234_5678);
    chk("rd_done_hresp", 64'(hresp), 0);
    @(negedge hclk); #1;
    chk("rd_idle_hrdata", 64'(hrdata), 0);

    // Decode miss on window 9
    ahb_req(40'h9000, 1'b1);
    n_err = 0;
    @(negedge hclk); ahb_idle(); #1;
    n_err += int'(err_int);
    chk("dec_err1_psel", 64'(psel), 0);
    chk("dec_err1_hready", 64'(hready_o), 0);
    chk("dec_err1_hresp", 64'(hresp), 1);
    @(negedge hclk); #1;
    n_err += int'(err_int);
    chk("dec_err2_hready", 64'(hready_o), 1);
    chk("dec_err2_hresp", 64'(hresp), 1);
    chk("dec_err2_psel", 64'(psel), 0);
    @(negedge hclk); #1;
    n_err += int'(err_int);
    chk("dec_err_pulses", 64'(n_err), 1);
    chk("dec_idle_hresp", 64'(hresp), 0);

    // PSLVERR from slave 1, then a back-to-back read of slave 0 taken in ERR2
    ahb_req(40'h1010, 1'b0); pslverr[1] = 1'b1; prdata[0 +: DW] = 32'hCAFE_0000;
    @(negedge hclk); ahb_idle(); #1;
    chk("slverr_setup_psel", 64'(psel), 64'h002);
    @(negedge hclk); #1;
    chk("slverr_acc_hready", 64'(hready_o), 0);
    chk("slverr_acc_hresp", 64'(hresp), 0);
    @(negedge hclk); #1;
    chk("slverr_err1_hresp", 64'(hresp), 1);
    chk("slverr_err1_int", 64'(err_int), 1);
    chk("slverr_err1_psel", 64'(psel), 0);
    @(negedge hclk); ahb_req(40'h0020, 1'b0); #1;
    chk("slverr_err2_hready", 64'(hready_o), 1);
    chk("slverr_err2_hresp", 64'(hresp), 1);
    @(negedge hclk); ahb_idle(); #1;
    chk("b2b_setup_psel", 64'(psel), 64'h001);
    chk("b2b_setup_paddr", 64'(paddr), 64'h0020);
    @(negedge hclk); #1;
    chk("b2b_done_hready", 64'(hready_o), 1);
    chk("b2b_done_hresp", 64'(hresp), 0);
    chk("b2b_done_hrdata", 64'(hrdata), 64'hCAFE_0000);
    pslverr = '0;

    // Timeout on slave 3 after four ACCESS cycles
    @(negedge hclk); ahb_req(40'h3000, 1'b0); pready[3] = 1'b0;
    @(negedge hclk); ahb_idle(); #1;
    chk("to_setup_psel", 64'(psel), 64'h008);
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk); #1;
      chk("to_acc_psel", 64'(psel), 64'h008);
      chk("to_acc_hready", 64'(hready_o), 0);
    end
    @(negedge hclk); pready[3] = 1'b1; #1;
    chk("to_err1_psel", 64'(psel), 0);
    chk("to_err1_penable", 64'(penable), 0);
    chk("to_err1_hready", 64'(hready_o), 0);
    chk("to_err1_hresp", 64'(hresp), 1);
    chk("to_err1_int", 64'(err_int), 1);
    @(negedge hclk); #1;
    chk("to_err2_hready", 64'(hready_o), 1);
    chk("to_err2_hresp", 64'(hresp), 1);
    @(negedge hclk); #1;
    chk("to_idle_hresp", 64'(hresp), 0);
    chk("to_idle_psel", 64'(psel), 0);

    // Reset during ACCESS, then a clean write to slave 6
    ahb_req(40'h4000, 1'b0); pready[4] = 1'b0;
    @(negedge hclk); ahb_idle(); #1;
    chk("rstx_setup_psel", 64'(psel), 64'h010);
    @(negedge hclk); #1;
    chk("rstx_acc_penable", 64'(penable), 1);
    hrst = 1'b1;
    @(negedge hclk); hrst = 1'b0; pready = '1; #1;
    chk("rstx_psel", 64'(psel), 0);
    chk("rstx_penable", 64'(penable), 0);
    chk("rstx_hready", 64'(hready_o), 1);
    chk("rstx_hresp", 64'(hresp), 0);
    ahb_req(40'h6000, 1'b1);
    @(negedge hclk); ahb_idle(); hwdata = 32'h0BAD_F00D; #1;
    chk("rstx_wr_psel", 64'(psel), 64'h040);
    chk("rstx_wr_pwdata", 64'(pwdata), 64'h0BAD_F00D);
    @(negedge hclk); #1;
    chk("rstx_wr_hready", 64'(hready_o), 1);
    chk("rstx_wr_hresp", 64'(hresp), 0);

    // Timeout disabled: access waits indefinitely for PREADY
    @(negedge hclk); hsel_nto = 1'b1; htrans = 2'b10; haddr = 40'h2000; hwrite = 1'b0;
    @(negedge hclk); hsel_nto = 1'b0; htrans = 2'b00; #1;
    chk("nto_setup_psel", 64'(nto_psel), 64'h04);
    repeat (300) @(negedge hclk);
    #1;
    chk("nto_wait_penable", 64'(nto_penable), 1);
    chk("nto_wait_psel", 64'(nto_psel), 64'h04);
    chk("nto_wait_hready", 64'(nto_hready), 0);
    chk("nto_wait_hresp", 64'(nto_hresp), 0);
    chk("nto_wait_err_int", 64'(nto_err_int), 0);
    chk("nto_wait_paddr", 64'(nto_paddr), 64'h2000);
    @(negedge hclk); pready_nto[2] = 1'b1; #1;
    chk("nto_done_hready", 64'(nto_hready), 1);
    chk("nto_done_hrdata", 64'(nto_hrdata), 64'h7777_0002);
    chk("nto_done_hresp", 64'(nto_hresp), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
